// File: rtl/seq_alu.sv
// seq_alu: eight-function ALU with a bit-serial shifter; define ALU_CARRY_CHAIN_EN to chain the stored carry into ADD/SUB.
// Latency 1 cycle (shift by k>0: k+1); the result is held in DONE until out_ready, and in_ready is high only in IDLE.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fs,
  input  logic [SW-1:0]    shamt,
  input  logic             use_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_SHL = 3'b010;
  localparam logic [2:0] FS_SHR = 3'b011;
  localparam logic [2:0] FS_ASR = 3'b100;
  localparam logic [2:0] FS_AND = 3'b101;
  localparam logic [2:0] FS_OR  = 3'b110;
  localparam logic [2:0] FS_XOR = 3'b111;

  state_t           state;
  logic [2:0]       op_q;
  logic [SW-1:0]    cnt_q;
  logic             carry_q;

  logic             is_sub;
  logic             is_shift;
  logic             cin;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [WIDTH-1:0] imm_y;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] step_y;
  logic             step_out;

`ifndef ALU_CARRY_CHAIN_EN
  // Without the carry chain these inputs have no effect on the datapath.
  logic unused_carry;
  assign unused_carry = use_carry ^ carry_q;
`endif

  always_comb begin
    is_sub   = (fs == FS_SUB);
    is_shift = (fs == FS_SHL) || (fs == FS_SHR) || (fs == FS_ASR);
`ifdef ALU_CARRY_CHAIN_EN
    cin = is_sub ? (1'b1 | (use_carry & carry_q)) : (use_carry & carry_q);
`else
    cin = is_sub;
`endif
    b_op  = is_sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    add_v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    imm_y = a;
    imm_c = 1'b0;
    imm_v = 1'b0;
    case (fs)
      FS_ADD, FS_SUB: begin
        imm_y = sum[WIDTH-1:0];
        imm_c = sum[WIDTH];
        imm_v = add_v;
      end
      FS_AND:  imm_y = a & b;
      FS_OR:   imm_y = a | b;
      FS_XOR:  imm_y = a ^ b;
      default: ; // shift by zero passes A through with c=0
    endcase
  end

  // One-bit shift step; y doubles as the shift register while in SHIFT.
  always_comb begin
    step_y   = {1'b0, y[WIDTH-1:1]};
    step_out = y[0];
    case (op_q)
      FS_SHL: begin
        step_y   = {y[WIDTH-2:0], 1'b0};
        step_out = y[WIDTH-1];
      end
      FS_ASR:  step_y = {y[WIDTH-1], y[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b1;
      carry_q   <= 1'b0;
      op_q      <= FS_ADD;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= fs;
            in_ready <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              y     <= a;
              cnt_q <= shamt;
              state <= SHIFT;
            end else begin
              y         <= imm_y;
              c         <= imm_c;
              v         <= imm_v;
              n         <= imm_y[WIDTH-1];
              z         <= (imm_y == '0);
              carry_q   <= imm_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          y     <= step_y;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            c         <= step_out;
            v         <= 1'b0;
            n         <= step_y[WIDTH-1];
            z         <= (step_y == '0);
            carry_q   <= step_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases then randomized ops against an arithmetic reference model.
module tb_seq_alu;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    fs = '0;
  logic [SW-1:0] shamt = '0;
  logic          use_carry = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  y;
  logic          c, v, n, z;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .fs(fs), .shamt(shamt), .use_carry(use_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c(c), .v(v), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       c, v, n, z;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  exp_t cur;
  bit   have_cur = 0;
  bit   prev_vld = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   hs_cyc = -100;
  int   model_carry = 0;
  bit   rdy_random = 0;
  logic rdy_level = 1'b1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input int ia, input int ib, input int ifs, input int ish, input int iuc);
    exp_t e;
    int sa, sb, full, sres, cin;
    bit chain;
    chain = 0;
`ifdef ALU_CARRY_CHAIN_EN
    chain = 1;
`endif
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    e.c = 1'b0;
    e.v = 1'b0;
    e.y = 8'(ia);
    case (ifs)
      0: begin
        cin  = (chain && iuc != 0) ? model_carry : 0;
        full = ia + ib + cin;
        sres = sa + sb + cin;
        e.y  = 8'(full);
        e.c  = (full > 255);
        e.v  = (sres > 127) || (sres < -128);
      end
      1: begin
        full = ia + (255 - ib) + 1;
        sres = sa - sb;
        e.y  = 8'(full);
        e.c  = (full > 255);
        e.v  = (sres > 127) || (sres < -128);
      end
      2: begin
        e.y = 8'(ia << ish);
        e.c = (ish != 0) && (((ia >> (8 - ish)) & 1) != 0);
      end
      3: begin
        e.y = 8'(ia >> ish);
        e.c = (ish != 0) && (((ia >> (ish - 1)) & 1) != 0);
      end
      4: begin
        e.y = 8'(sa >>> ish);
        e.c = (ish != 0) && (((ia >> (ish - 1)) & 1) != 0);
      end
      5: e.y = 8'(ia & ib);
      6: e.y = 8'(ia | ib);
      default: e.y = 8'(ia ^ ib);
    endcase
    e.n   = e.y[7];
    e.z   = (e.y == 8'h00);
    e.lat = ((ifs == 2 || ifs == 3 || ifs == 4) && ish != 0) ? ish + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] ey, input logic ec, ev, en, ez, input int lat);
    exp_t e;
    e.y = ey; e.c = ec; e.v = ev; e.n = en; e.z = ez; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  // Monitor: pops an expectation when a result appears, re-checks it every held cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_vld = 0;
      have_cur = 0;
    end else begin
      if (out_valid) begin
        if (!prev_vld) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            have_cur = 0;
            $display("FAIL unexpected_result: got out_valid=1 y=%0h, required no result (cycle %0d)", y, cyc);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            check("latency", cyc - cur.acc + 1, cur.lat);
          end
        end
        if (have_cur) begin
          check("y", y, cur.y);
          check("c", c, cur.c);
          check("v", v, cur.v);
          check("n", n, cur.n);
          check("z", z, cur.z);
        end
        if (out_ready) hs_cyc = cyc + 1;
      end
      prev_vld = out_valid;
    end
  end

  task automatic issue(input logic [7:0] ia, ib, input logic [2:0] ifs, input logic [2:0] ish,
                       input logic iuc, input exp_t e);
    a = ia; b = ib; fs = ifs; shamt = ish; use_carry = iuc;
    in_valid = 1'b1;
    pend = e;
    model_carry = e.c ? 1 : 0;
  endtask

  task automatic wait_accept(output int acc);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=%b, required 1 within 300 cycles", in_ready);
      acc = -1;
    end else begin
      acc = cyc + 1;
      pend.acc = acc;
      exp_q.push_back(pend);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); fs = 3'($urandom_range(0, 7));
  endtask

  task automatic send(input logic [7:0] ia, ib, input logic [2:0] ifs, input logic [2:0] ish,
                      input logic iuc, input exp_t e);
    int acc;
    issue(ia, ib, ifs, ish, iuc, e);
    wait_accept(acc);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1 && out_valid === 1'b0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0 within 400 cycles", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, seen;
    logic [7:0] ra, rb;
    logic [2:0] rfs, rsh;
    logic       ruc;

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y", y, 0);
    check("rst_c", c, 0);
    check("rst_v", v, 0);
    check("rst_n", n, 0);
    check("rst_z", z, 1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    send(8'h7F, 8'h01, 3'd0, 3'd0, 1'b0, mk(8'h80, 0, 1, 1, 0, 1));
    send(8'h05, 8'h05, 3'd1, 3'd0, 1'b0, mk(8'h00, 1, 0, 0, 1, 1));
    send(8'hC0, 8'h00, 3'd2, 3'd1, 1'b0, mk(8'h80, 1, 0, 1, 0, 2));
    send(8'h81, 8'h00, 3'd3, 3'd3, 1'b0, mk(8'h10, 0, 0, 0, 0, 4));
    send(8'h80, 8'h00, 3'd4, 3'd7, 1'b0, mk(8'hFF, 0, 0, 1, 0, 8));
    send(8'hFF, 8'h01, 3'd0, 3'd0, 1'b0, mk(8'h00, 1, 0, 0, 1, 1));
`ifdef ALU_CARRY_CHAIN_EN
    send(8'h00, 8'h00, 3'd0, 3'd0, 1'b1, mk(8'h01, 0, 0, 0, 0, 1));
`else
    send(8'h00, 8'h00, 3'd0, 3'd0, 1'b1, mk(8'h00, 0, 0, 0, 1, 1));
`endif
    wait_drain();

    // Consumer stalls for 5 cycles while the next request is already waiting.
    rdy_level = 1'b0;
    @(negedge clk);
    send(8'h12, 8'h34, 3'd0, 3'd0, 1'b0, mk(8'h46, 0, 0, 0, 0, 1));
    issue(8'h50, 8'h50, 3'd0, 3'd0, 1'b0, mk(8'hA0, 0, 1, 1, 0, 1));
    seen = 0;
    while (out_valid !== 1'b1 && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    repeat (5) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(negedge clk);
    end
    rdy_level = 1'b1;
    wait_accept(acc);
    check("accept_after_handshake", acc, hs_cyc + 1);
    wait_drain();

    // Reset aborts a long shift; the carry register must also clear.
    send(8'hFF, 8'h01, 3'd0, 3'd0, 1'b0, mk(8'h00, 1, 0, 0, 1, 1));
    wait_drain();
    a = 8'hA5; fs = 3'd3; shamt = 3'd7; use_carry = 1'b0; in_valid = 1'b1;
    seen = 0;
    while (in_ready !== 1'b1 && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_carry = 0;
    check("abort_out_valid", out_valid, 0);
    check("abort_z", z, 1);
    check("abort_y", y, 0);
    check("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_result", seen, 0);
    send(8'h00, 8'h00, 3'd0, 3'd0, 1'b1, mk(8'h00, 0, 0, 0, 1, 1));
    wait_drain();

    rdy_random = 1;
    repeat (200) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rfs = 3'($urandom_range(0, 7));
      rsh = 3'($urandom_range(0, 7));
      ruc = 1'($urandom_range(0, 1));
      send(ra, rb, rfs, rsh, ruc, model(int'(ra), int'(rb), int'(rfs), int'(rsh), int'(ruc)));
    end
    wait_drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits; legal values are powers of two, 4 to 64.
REQ-002 SHALL have parameter SW, default $clog2(WIDTH), shift-amount width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port fs  input  3  function select.
REQ-010 SHALL have port shamt  input  SW  shift distance.
REQ-011 SHALL have port use_carry  input  1  add stored carry flag (see REQ-032).
REQ-012 SHALL have port out_valid  output  1  result and flags valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port y  output  WIDTH  registered result.
REQ-015 SHALL have ports c, v, n, z  output  1 each  carry, overflow, negative and zero flags, registered.

Function
REQ-016 SHALL decode fs as: 000 ADD A+B; 001 SUB A+~B+1; 010 SHL; 011 SHR (logical); 100 ASR; 101 AND; 110 OR; 111 XOR.
REQ-017 SHALL run an FSM with states IDLE, SHIFT and DONE, and SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL accept a request on the rising edge where in_valid and in_ready are both 1, capturing a, b, fs, shamt and use_carry.
REQ-019 SHALL, for non-shift ops and for shifts with shamt=0, compute the result on the accept edge and enter DONE (latency 1 cycle).
REQ-020 SHALL, for shifts with shamt=k>0, load A and enter SHIFT, shift 1 bit per cycle for k cycles, then enter DONE (latency k+1 cycles).
REQ-021 SHALL make c equal to the last bit shifted out for shifts; c=0 for shamt=0.
REQ-022 SHALL make c the adder carry-out for ADD/SUB (SUB: c=1 means no borrow), and c=0 for logic ops.
REQ-023 SHALL make v the two's-complement overflow for ADD/SUB, and v=0 for all other ops.
REQ-024 SHALL make n=y[WIDTH-1] and z=(y==0) for every op.
REQ-025 SHALL assert out_valid only in DONE, and hold y and the flags stable while out_valid=1 and out_ready=0.
REQ-026 SHALL move from DONE to IDLE on the edge where out_valid and out_ready are both 1; a new request is accepted no earlier than the following edge.
REQ-027 SHALL ignore in_valid outside IDLE.
REQ-028 SHALL keep an internal carry register, updated from c on each DONE entry.

Reset
REQ-029 SHALL, on a reset edge, force state IDLE, out_valid=0, y=0, c=v=n=0, z=1 and carry register=0.
REQ-030 SHALL give reset priority over all other events, aborting any SHIFT or DONE in progress with no result delivered.
REQ-031 SHALL have in_ready=1 in the cycle after reset deasserts.

Configuration
REQ-032 SHALL, with ALU_CARRY_CHAIN_EN defined, use the carry register as carry-in for ADD and use carry-in=1 OR carry register for SUB, when use_carry=1 at accept.
REQ-033 SHALL, without ALU_CARRY_CHAIN_EN, ignore use_carry, use carry-in 0 for ADD and 1 for SUB, and omit no ports.

Verification
REQ-034 SHALL cover: WIDTH=8, ADD a=0x7F b=0x01 -> y=0x80 v=1 n=1 c=0 z=0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: SUB a=0x05 b=0x05 -> y=0x00 z=1 c=1 v=0; SHL a=0xC0 shamt=1 -> y=0x80 c=1, latency 2.
REQ-036 SHALL cover: SHR a=0x81 shamt=3 -> y=0x10 c=0, latency 4; ASR a=0x80 shamt=7 -> y=0xFF c=0 n=1, latency 8.
REQ-037 SHALL cover: ADD 0xFF+0x01 (y=0x00 c=1), then ADD 0x00+0x00 with use_carry=1 -> y=0x01 with the macro defined, y=0x00 without.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> y and flags unchanged, in_ready=0, held in_valid not accepted until 1 cycle after the handshake.
REQ-039 SHALL cover: reset pulsed during SHR shamt=7 at cycle 3 -> out_valid=0, z=1, in_ready=1 next cycle, and no stale result afterwards.
